// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, oversampling tick divider, mid-bit sampling FSM.
// Emits a one-clk data_valid on a good stop bit or a one-clk frame_err on a low stop bit.
module uart_rx #(
   parameter int unsigned CLOCK_FREQ = 50000000,
   parameter int unsigned BAUD_RATE  = 115200,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       frame_err,
   output logic       busy
);
   localparam int unsigned TickDiv = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
   localparam int unsigned DivMax  = (TickDiv > 0) ? TickDiv - 1 : 0;
   localparam int unsigned DivW    = (DivMax > 0) ? $clog2(DivMax + 1) : 1;
   localparam int unsigned TickW   = $clog2(OVERSAMPLE + 1);
   localparam logic [TickW-1:0] MidTick = TickW'(OVERSAMPLE / 2 - 1);
   localparam logic [TickW-1:0] BitTick = TickW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitIdle} state_e;

   logic             rx_meta_q, rx_s_q, rx_prev_q, rx_prev_d;
   logic [1:0]       init_q, init_d;
   state_e           state_q, state_d;
   logic [DivW-1:0]  div_q, div_d;
   logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       data_out_q, data_out_d;
   logic             data_valid_q, data_valid_d;
   logic             frame_err_q, frame_err_d;
   logic             busy_q, busy_d;
   logic             sample_tick, fall;

   // rx_prev only tracks rx_s once the synchronizer holds real line samples, so a line
   // that is already low when reset releases never looks like a start edge.
   assign init_d      = {init_q[0], 1'b1};
   assign rx_prev_d   = rx_s_q & init_q[1];
   assign fall        = rx_prev_q & ~rx_s_q;
   assign sample_tick = (state_q != StIdle) && (div_q == DivW'(DivMax));

   always_comb begin
      state_d      = state_q;
      tick_cnt_d   = tick_cnt_q;
      bit_idx_d    = bit_idx_q;
      shift_d      = shift_q;
      data_out_d   = data_out_q;
      data_valid_d = 1'b0;
      frame_err_d  = 1'b0;
      busy_d       = busy_q;
      if (state_q == StIdle || sample_tick) begin
         div_d = '0;
      end else begin
         div_d = div_q + 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            tick_cnt_d = '0;
            bit_idx_d  = '0;
            if (fall) begin
               state_d = StStart;
               busy_d  = 1'b1;
            end
         end
         StStart: begin
            if (sample_tick) begin
               if (tick_cnt_q == MidTick) begin
                  tick_cnt_d = '0;
                  if (rx_s_q) begin
                     state_d = StIdle;
                     busy_d  = 1'b0;
                  end else begin
                     state_d = StData;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
         end
         StData: begin
            if (sample_tick) begin
               if (tick_cnt_q == BitTick) begin
                  tick_cnt_d = '0;
                  shift_d    = {rx_s_q, shift_q[7:1]};
                  bit_idx_d  = bit_idx_q + 3'd1;
                  if (bit_idx_q == 3'd7) state_d = StStop;
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
         end
         StStop: begin
            if (sample_tick) begin
               if (tick_cnt_q == BitTick) begin
                  tick_cnt_d = '0;
                  if (rx_s_q) begin
                     data_out_d   = shift_q;
                     data_valid_d = 1'b1;
                     state_d      = StIdle;
                     busy_d       = 1'b0;
                  end else begin
                     frame_err_d = 1'b1;
                     state_d     = StWaitIdle;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
         end
         StWaitIdle: begin
            if (rx_s_q) begin
               state_d = StIdle;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = StIdle;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_q    <= 1'b1;
         rx_s_q       <= 1'b1;
         rx_prev_q    <= 1'b0;
         init_q       <= 2'b00;
         state_q      <= StIdle;
         div_q        <= '0;
         tick_cnt_q   <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         rx_meta_q    <= rx;
         rx_s_q       <= rx_meta_q;
         rx_prev_q    <= rx_prev_d;
         init_q       <= init_d;
         state_q      <= state_d;
         div_q        <= div_d;
         tick_cnt_q   <= tick_cnt_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         frame_err_q  <= frame_err_d;
         busy_q       <= busy_d;
      end
   end

   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign frame_err  = frame_err_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at a scaled bit rate (16 clk/bit, 8 ticks of 2 clk per bit)
// so the full 0x00..0xFF sweep stays short.
module tb_uart_rx;
   localparam int unsigned ClkFreq = 1000000;
   localparam int unsigned Baud    = 62500;
   localparam int unsigned Os      = 8;
   localparam int          BitClks = ClkFreq / Baud;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic [7:0] data_out;
   logic       data_valid, frame_err, busy;

   uart_rx #(
      .CLOCK_FREQ(ClkFreq),
      .BAUD_RATE (Baud),
      .OVERSAMPLE(Os)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .data_out  (data_out),
      .data_valid(data_valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int         n_cmp = 0;
   int         n_err = 0;
   int         dv_cnt = 0, fe_cnt = 0, both_cnt = 0, busy_rise = 0, busy_fall = 0;
   logic       busy_prev = 1'b0;
   logic [7:0] got_q[$];

   always @(negedge clk) begin
      if (data_valid) begin
         dv_cnt++;
         got_q.push_back(data_out);
      end
      if (frame_err) fe_cnt++;
      if (data_valid && frame_err) both_cnt++;
      if (busy && !busy_prev) busy_rise++;
      if (!busy && busy_prev) busy_fall++;
      busy_prev = busy;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx = f[i];
         repeat (BitClks) @(negedge clk);
      end
   endtask

   int dv0, fe0, br0, bf0, q0;

   initial begin
      // Reset values
      repeat (3) @(negedge clk);
      check("rst_data_out", 32'(data_out), 32'h00);
      check("rst_data_valid", 32'(data_valid), 32'h0);
      check("rst_frame_err", 32'(frame_err), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      rst = 1'b0;
      repeat (20) @(negedge clk);

      // Single byte 0x55
      dv0 = dv_cnt; fe0 = fe_cnt; q0 = got_q.size();
      send_byte(8'h55, 1'b1);
      repeat (2 * BitClks) @(negedge clk);
      check("b55_dv_count", dv_cnt - dv0, 1);
      check("b55_data_out", 32'(data_out), 32'h55);
      check("b55_fe_count", fe_cnt - fe0, 0);
      check("b55_busy_idle", 32'(busy), 32'h0);

      // Back-to-back 0xA5, 0x3C with one stop bit each
      dv0 = dv_cnt; q0 = got_q.size(); bf0 = busy_fall;
      send_byte(8'hA5, 1'b1);
      send_byte(8'h3C, 1'b1);
      repeat (2 * BitClks) @(negedge clk);
      check("b2b_dv_count", dv_cnt - dv0, 2);
      if (got_q.size() >= q0 + 2) begin
         check("b2b_first", 32'(got_q[q0]), 32'hA5);
         check("b2b_second", 32'(got_q[q0 + 1]), 32'h3C);
      end
      check("b2b_busy_drops", busy_fall - bf0, 2);

      // Short low glitch on an idle line
      dv0 = dv_cnt; fe0 = fe_cnt; br0 = busy_rise;
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (16) @(negedge clk);
      check("glitch_busy_seen", busy_rise - br0, 1);
      check("glitch_busy_clear", 32'(busy), 32'h0);
      repeat (3 * BitClks) @(negedge clk);
      check("glitch_dv", dv_cnt - dv0, 0);
      check("glitch_fe", fe_cnt - fe0, 0);

      // Low stop bit followed by a long break
      dv0 = dv_cnt; fe0 = fe_cnt; br0 = busy_rise;
      send_byte(8'hF0, 1'b0);
      repeat (2000) @(negedge clk);
      check("ferr_fe_count", fe_cnt - fe0, 1);
      check("ferr_dv_count", dv_cnt - dv0, 0);
      check("ferr_data_out_kept", 32'(data_out), 32'h3C);
      check("ferr_busy_in_break", 32'(busy), 32'h1);
      rx = 1'b1;
      repeat (5) @(negedge clk);
      check("ferr_busy_after_break", 32'(busy), 32'h0);
      repeat (3 * BitClks) @(negedge clk);
      check("ferr_no_new_frame", busy_rise - br0, 1);
      check("ferr_dv_after", dv_cnt - dv0, 0);

      // Reset during data bit 4 of 0x4A (bit 4 low, so the line is low at release)
      dv0 = dv_cnt; fe0 = fe_cnt;
      rx = 1'b0;
      repeat (BitClks) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx = (8'h4A >> i) & 8'h01;
         repeat (BitClks) @(negedge clk);
      end
      rx = 1'b0;
      repeat (BitClks / 2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mrst_data_out", 32'(data_out), 32'h00);
      check("mrst_busy", 32'(busy), 32'h0);
      repeat (4) @(negedge clk);
      rst = 1'b0;
      br0 = busy_rise;
      repeat (40) @(negedge clk);
      check("mrst_low_line_no_start", busy_rise - br0, 0);
      check("mrst_no_pulses", (dv_cnt - dv0) + (fe_cnt - fe0), 0);
      rx = 1'b1;
      repeat (3 * BitClks) @(negedge clk);
      send_byte(8'h81, 1'b1);
      repeat (2 * BitClks) @(negedge clk);
      check("mrst_next_dv", dv_cnt - dv0, 1);
      check("mrst_next_data", 32'(data_out), 32'h81);

      // Every byte value, back-to-back
      dv0 = dv_cnt; q0 = got_q.size();
      for (int b = 0; b < 256; b++) send_byte(8'(b), 1'b1);
      repeat (2 * BitClks) @(negedge clk);
      check("sweep_dv_count", dv_cnt - dv0, 256);
      for (int i = 0; i < 256; i++) begin
         if (got_q.size() > q0 + i) check("sweep_byte", 32'(got_q[q0 + i]), i);
      end

      check("never_dv_and_fe", both_cnt, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The module SHALL have parameter CLOCK_FREQ, default 50000000, giving the system clock frequency in Hz.
REQ-002 The module SHALL have parameter BAUD_RATE, default 115200, giving the serial bit rate in bit/s.
REQ-003 The module SHALL have parameter OVERSAMPLE, default 16, giving the sample ticks per bit period.
REQ-004 The module SHALL have port clk, input, 1 bit: system clock, rising edge active.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The module SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-007 The module SHALL have port data_out, output, 8 bits: last correctly received byte.
REQ-008 The module SHALL have port data_valid, output, 1 bit: one-clk pulse when data_out is updated.
REQ-009 The module SHALL have port frame_err, output, 1 bit: one-clk pulse when a stop bit is sampled low.
REQ-010 The module SHALL have port busy, output, 1 bit: high from start detection until return to IDLE.

Function
REQ-011 The frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, stop bit 1, matching the team's uart_tx.
REQ-012 rx SHALL pass through a 2-flop synchronizer, both flops resetting to 1; all logic SHALL use the synchronized value rx_s.
REQ-013 A tick divider SHALL pulse sample_tick for one clk every TICK_DIV = CLOCK_FREQ/(BAUD_RATE*OVERSAMPLE) clocks, using integer division (27 at defaults).
REQ-014 The divider SHALL be held at 0 in IDLE and restarted from 0 on the clock where a start edge is detected.
REQ-015 The FSM SHALL have states IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-016 In IDLE, detection of rx_s==0 with the previous rx_s==1 (falling edge) SHALL move the FSM to START and set busy.
REQ-017 In START, at tick count OVERSAMPLE/2 (mid-bit), rx_s==1 SHALL be treated as a glitch and return the FSM to IDLE with no output pulse; rx_s==0 SHALL move the FSM to DATA with the tick count cleared.
REQ-018 In DATA, each bit SHALL be sampled at every OVERSAMPLE-th tick after the mid-start point and shifted in LSB first; a 3-bit index SHALL count 0..7, and after bit 7 the FSM SHALL move to STOP.
REQ-019 In STOP, at mid-bit with rx_s==1: data_out SHALL load the shifted byte, data_valid SHALL pulse on the same clk, and the FSM SHALL move to IDLE with busy cleared.
REQ-020 In STOP, at mid-bit with rx_s==0: frame_err SHALL pulse, data_out SHALL remain unchanged, and the FSM SHALL move to WAIT_IDLE.
REQ-021 WAIT_IDLE SHALL hold busy high until rx_s==1, then return to IDLE; a held-low line (break) SHALL therefore never start a new frame.
REQ-022 data_valid and frame_err SHALL never be high on the same clk, and each SHALL be high for exactly one clk per frame.
REQ-023 A falling edge arriving while the FSM is in STOP after the sample, or in the first clk of IDLE, SHALL be detected, so that back-to-back frames with a single stop bit are received without loss.
REQ-024 data_out SHALL hold its value between frames; no ready/acknowledge input exists, and an unread byte SHALL be overwritten by the next one.
REQ-025 The latency from the mid-stop-bit sample instant on rx to data_valid SHALL be 3 clks or fewer (2-flop synchronizer plus 1 register).

Reset
REQ-026 While rst is high: data_out SHALL be 0x00, data_valid, frame_err and busy SHALL be 0, the FSM SHALL be IDLE, and the divider, tick count and bit index SHALL be 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no pulse on any output.
REQ-028 After reset release, a line already low SHALL not start a frame until a high-to-low edge is seen.

Verification
REQ-029 Send 0x55 at 115200 baud (434 clk/bit) -> one data_valid pulse, data_out=0x55, frame_err never high.
REQ-030 Send 0xA5 and then 0x3C back-to-back with one stop bit each -> two data_valid pulses with 0xA5 then 0x3C; busy drops between the frames.
REQ-031 Apply a 100-clk low glitch on an idle line -> no data_valid, no frame_err, and busy returns to 0 within 8 ticks.
REQ-032 Send 0xF0 with the stop bit forced low, then hold rx low for 2000 clks, then raise it -> one frame_err pulse, data_out unchanged, busy stays high until rx goes high, and no further frame is received.
REQ-033 Assert rst for 5 clks during data bit 4 of a frame -> all outputs 0; a following 0x81 is received correctly.
REQ-034 Drive the bench from uart_tx in loopback with bytes 0x00..0xFF -> 256 data_valid pulses, each data_out equal to the byte sent.
